// File: rtl/hw_entrada_irq_if.sv
// Avalon-MM slave bus of the input PIO: 2-bit word address, write strobe and
// data in, registered read data and the interrupt request out.
interface hw_entrada_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/hw_entrada_irq.sv
// Input PIO with synchronizer, per-bit edge capture (W1C), irq mask and level/edge irq.
// Read latency 1 clock, data re-registered every cycle; slave never stalls the bus.
module hw_entrada_irq #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_port,
  hw_entrada_irq_if.slave       bus
);

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0] s;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;
  logic [DATA_WIDTH-1:0] w1c;
  logic [31:0]           readdata_q, readdata_d;
  logic                  wr;
  logic                  unused_wd;

  assign s         = sync_q[SYNC_STAGES-1];
  assign wr        = bus.chipselect & ~bus.write_n;
  assign unused_wd = ^bus.writedata;

  always_comb begin
    if (EDGE_TYPE == 0) begin
      edge_det = s & ~prev_q;
    end else if (EDGE_TYPE == 1) begin
      edge_det = ~s & prev_q;
    end else begin
      edge_det = s ^ prev_q;
    end
  end

  // A newly detected edge is OR-ed in after the clear, so set beats W1C.
  always_comb begin
    mask_d = mask_q;
    w1c    = '0;
    if (wr && bus.address == 2'd2) mask_d = bus.writedata[DATA_WIDTH-1:0];
    if (wr && bus.address == 2'd3) w1c    = bus.writedata[DATA_WIDTH-1:0];
    cap_d = (cap_q & ~w1c) | edge_det;

    readdata_d = '0;
    case (bus.address)
      2'd0:    readdata_d[DATA_WIDTH-1:0] = s;
      2'd2:    readdata_d[DATA_WIDTH-1:0] = mask_q;
      2'd3:    readdata_d[DATA_WIDTH-1:0] = cap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      prev_q     <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q     <= s;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;

  // irq is a pure AND/OR of flops, so masking drops it the cycle mask_q updates.
  generate
    if (IRQ_MODE == 1) begin : g_irq_level
      assign bus.irq = |(s & mask_q);
    end else begin : g_irq_edge
      assign bus.irq = |(cap_q & mask_q);
    end
  endgenerate

endmodule
